// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: sequences UART RX bytes (A, B, opcode) into the ALU and
// hands the ALU result to the UART TX with a start/done handshake.
// Optional build macro UART_CTRL_TIMEOUT_EN adds an inter-byte timeout in
// WAIT_B / WAIT_OP; without it the controller waits indefinitely.
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_A     | idle, waiting for operand A
// WAIT_B     | A captured, waiting for operand B
// WAIT_OP    | A and B captured, waiting for opcode
// EXEC       | drive A/B/op to the ALU as one coherent triplet
// SEND       | capture ALU result, request transmission
// WAIT_TX    | waiting for transmitter to finish
module uart_alu_ctrl #(
  parameter int N_DATA         = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_DATA-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_rx_err,
  input  logic [N_DATA-1:0] i_alu_result,
  input  logic              i_tx_done,
  output logic [N_DATA-1:0] o_data_a,
  output logic [N_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]  o_op,
  output logic [N_DATA-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_drop,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [N_DATA-1:0] r_reg_a;
  logic [N_DATA-1:0] r_reg_b;
  logic [NB_OP-1:0]  r_reg_op;
  logic [N_DATA-1:0] r_data_a;
  logic [N_DATA-1:0] r_data_b;
  logic [NB_OP-1:0]  r_op;
  logic [N_DATA-1:0] r_tx_data;
  logic              r_tx_start;
  logic              r_drop;

  logic w_good;
  logic w_legal;
  logic w_timeout;
  logic w_drop;
  logic w_load_a;
  logic w_load_b;
  logic w_load_op;
  logic w_exec;
  logic w_send;

  // Whole byte is compared so that any bit above the opcode field makes it illegal.
  function automatic logic f_legal_op(input logic [N_DATA-1:0] b);
    logic ok;
    case (b)
      N_DATA'(8'h20), N_DATA'(8'h22), N_DATA'(8'h24), N_DATA'(8'h25),
      N_DATA'(8'h26), N_DATA'(8'h27), N_DATA'(8'h03), N_DATA'(8'h02): ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_good  = i_rx_valid & ~i_rx_err;
  assign w_legal = f_legal_op(i_rx_data);

`ifdef UART_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_in_wait;

  assign w_in_wait = (r_state == WAIT_B) || (r_state == WAIT_OP);
  assign w_timeout = w_in_wait && (r_tmo_cnt == '0);

  // Down-counter reloaded on any byte or state change; terminal count zero means timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if ((w_state_next != r_state) || i_rx_valid) begin
      r_tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (w_in_wait && (r_tmo_cnt != '0)) begin
      r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle strobes; a byte arriving while busy is always dropped.
  always_comb begin
    w_state_next = r_state;
    w_drop       = 1'b0;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_op    = 1'b0;
    w_exec       = 1'b0;
    w_send       = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (w_good) begin
          w_load_a     = 1'b1;
          w_state_next = WAIT_B;
        end else if (i_rx_valid) begin
          w_drop = 1'b1;
        end
      end
      WAIT_B: begin
        if (w_good) begin
          w_load_b     = 1'b1;
          w_state_next = WAIT_OP;
        end else if (i_rx_valid || w_timeout) begin
          w_drop       = 1'b1;
          w_state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (w_good && w_legal) begin
          w_load_op    = 1'b1;
          w_state_next = EXEC;
        end else if (i_rx_valid || w_timeout) begin
          w_drop       = 1'b1;
          w_state_next = WAIT_A;
        end
      end
      EXEC: begin
        w_exec       = 1'b1;
        w_drop       = i_rx_valid;
        w_state_next = SEND;
      end
      SEND: begin
        w_send       = 1'b1;
        w_drop       = i_rx_valid;
        w_state_next = WAIT_TX;
      end
      WAIT_TX: begin
        w_drop = i_rx_valid;
        if (i_tx_done) begin
          w_state_next = WAIT_A;
        end
      end
      default: begin
        w_state_next = WAIT_A;
      end
    endcase
  end

  // Holding registers, ALU-facing triplet, TX byte and one-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg_a    <= '0;
      r_reg_b    <= '0;
      r_reg_op   <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_op       <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (w_load_a)  r_reg_a  <= i_rx_data;
      if (w_load_b)  r_reg_b  <= i_rx_data;
      if (w_load_op) r_reg_op <= i_rx_data[NB_OP-1:0];
      if (w_exec) begin
        r_data_a <= r_reg_a;
        r_data_b <= r_reg_b;
        r_op     <= r_reg_op;
      end
      if (w_send) r_tx_data <= i_alu_result;
      r_tx_start <= w_send;
      r_drop     <= w_drop;
    end
  end

  assign o_data_a   = r_data_a;
  assign o_data_b   = r_data_b;
  assign o_op       = r_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_drop     = r_drop;
  assign o_busy     = (r_state == EXEC) || (r_state == SEND) || (r_state == WAIT_TX);

endmodule
